mmio_ctrl: RTL and testbench
============================

MMIO_CTRL -- requirements
Module: mmio_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have port mem_adrM, input, 32 bits: memory-stage byte address from the core.
REQ-004 SHALL have port mem_wdataM, input, 32 bits: store data.
REQ-005 SHALL have port wea, input, 4 bits: store byte enables; any bit set means a store.
REQ-006 SHALL have port mem_re, input, 1 bit: memory-stage load strobe.
REQ-007 SHALL have port instr_stop, input, 1 bit: core stalled or redirecting this cycle.
REQ-008 SHALL have port io_dout, output, 32 bits: registered read data, consumed by writeback.
REQ-009 SHALL have port uart_tx_data, output, 8 bits: byte to UART transmitter.
REQ-010 SHALL have port uart_tx_valid, output, 1 bit: uart_tx_data is valid.
REQ-011 SHALL have port uart_tx_ready, input, 1 bit: transmitter accepts the byte.
REQ-012 SHALL have port uart_rx_data, input, 8 bits: byte from UART receiver.
REQ-013 SHALL have port uart_rx_valid, input, 1 bit: uart_rx_data is valid.
REQ-014 SHALL have port uart_rx_ready, output, 1 bit: block accepts the rx byte.

Function
REQ-015 SHALL decode IO when mem_adrM[31:28]==4'h8; other addresses SHALL cause no access, no side effect, and io_dout=0 on the next cycle.
REQ-016 SHALL use this map: 0x80000000 R status {30'b0, rx_nonempty, tx_free}; 0x80000004 R rx byte (pop); 0x80000008 W tx byte; 0x80000010 R cycle counter; 0x80000014 R instruction counter; 0x80000018 W counter reset; unmapped IO reads return 0.
REQ-017 SHALL register io_dout, read latency 1 cycle: value selected by mem_adrM in cycle N appears in cycle N+1, whether or not mem_re is high.
REQ-018 SHALL treat reads as side-effecting only when mem_re=1; an rx pop requires mem_re=1 at 0x80000004.
REQ-019 SHALL buffer rx in a 4-entry FIFO with 2-bit wrapping pointers and a 3-bit occupancy count.
REQ-020 SHALL drive uart_rx_ready = FIFO not full; push when uart_rx_valid && uart_rx_ready.
REQ-021 SHALL, on a pop read with FIFO non-empty, return {24'b0, head byte} and advance the head; with FIFO empty, return 0 and leave state unchanged.
REQ-022 SHALL, on simultaneous push and pop, update both and keep occupancy unchanged; a push into an empty FIFO is not visible to a pop in the same cycle.
REQ-023 SHALL hold tx in one holding register: a store with wea!=0 to 0x80000008 while tx_free=1 loads mem_wdataM[7:0] and asserts uart_tx_valid next cycle.
REQ-024 SHALL keep uart_tx_valid and uart_tx_data stable until a cycle with uart_tx_ready=1, then deassert uart_tx_valid next cycle; tx_free = !uart_tx_valid.
REQ-025 SHALL silently drop a tx store while tx_free=0.
REQ-026 SHALL increment the 32-bit cycle counter every cycle and wrap 0xFFFFFFFF to 0.
REQ-027 SHALL increment the 32-bit instruction counter when instr_stop=0 and wrap the same way.
REQ-028 SHALL zero both counters on the next edge after any store to 0x80000018; reset wins over a same-cycle increment.

Reset
REQ-029 SHALL, with rst=1 at an edge, clear io_dout, uart_tx_valid, uart_tx_data, FIFO pointers/count, and both counters to 0; uart_rx_ready SHALL be 1 after reset.
REQ-030 SHALL let rst abort an in-flight tx (valid dropped, byte lost) and discard FIFO contents.

Verification
REQ-031 SHALL cover: reset, idle 10 cycles, read 0x80000010 -> io_dout=10 (+/-1 per sample-point definition, fixed in bench), status read = 0x1.
REQ-032 SHALL cover: push 0x41,0x42,0x43,0x44,0x45 with no reads -> uart_rx_ready low after the 4th, 5th held off; pops return 0x41..0x44, then 0x45 after it is accepted.
REQ-033 SHALL cover: store 0x5A to 0x80000008 with uart_tx_ready=0 for 3 cycles -> valid held with data 0x5A; second store 0x11 dropped; ready=1 -> valid clears; status bit0=1.
REQ-034 SHALL cover: instr_stop high 4 of 10 cycles after counter reset -> instruction counter=6, cycle counter=10.
REQ-035 SHALL cover: preload cycle counter near 0xFFFFFFFE via force -> wraps to 0; counter-reset store coincident with increment -> reads 0 next cycle.
REQ-036 SHALL cover: rst mid-tx and with 2 FIFO entries -> tx_valid=0, status=0x1, pop returns 0.

Source files
------------

// File: rtl/mmio_ctrl.sv
// Memory-mapped IO block for the core's memory stage: status, UART rx FIFO,
// UART tx holding register and free-running cycle/instruction counters.
module mmio_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_adrM,
    input  logic [31:0] mem_wdataM,
    input  logic [3:0]  wea,
    input  logic        mem_re,
    input  logic        instr_stop,
    output logic [31:0] io_dout,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_valid,
    input  logic        uart_tx_ready,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rx_valid,
    output logic        uart_rx_ready
);

    localparam logic [31:0] ADR_STATUS = 32'h8000_0000;
    localparam logic [31:0] ADR_RX     = 32'h8000_0004;
    localparam logic [31:0] ADR_TX     = 32'h8000_0008;
    localparam logic [31:0] ADR_CYC    = 32'h8000_0010;
    localparam logic [31:0] ADR_INSTR  = 32'h8000_0014;
    localparam logic [31:0] ADR_CRST   = 32'h8000_0018;

    localparam logic [2:0]  FIFO_DEPTH = 3'd4;

    logic        io_sel;
    logic        is_store;
    logic        hit_rx;
    logic        hit_tx;
    logic        hit_crst;

    assign io_sel   = (mem_adrM[31:28] == 4'h8);
    assign is_store = |wea;
    assign hit_rx   = (mem_adrM == ADR_RX);
    assign hit_tx   = (mem_adrM == ADR_TX);
    assign hit_crst = (mem_adrM == ADR_CRST);

    // Only the low byte of store data reaches the transmitter.
    logic unused_wdata;
    assign unused_wdata = ^mem_wdataM[31:8];

    // ---------------- rx FIFO ----------------
    logic [7:0] fifo_mem_q [4];
    logic [1:0] wr_ptr_q, wr_ptr_d;
    logic [1:0] rd_ptr_q, rd_ptr_d;
    logic [2:0] cnt_q, cnt_d;
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_push;
    logic       fifo_pop;

    assign fifo_full  = (cnt_q == FIFO_DEPTH);
    assign fifo_empty = (cnt_q == 3'd0);
    assign fifo_push  = uart_rx_valid && !fifo_full;
    // Emptiness is judged on the registered count, so a same-cycle push
    // into an empty FIFO cannot be popped until the following cycle.
    assign fifo_pop   = mem_re && hit_rx && !fifo_empty;

    assign uart_rx_ready = !fifo_full;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (fifo_push) begin
            wr_ptr_d = wr_ptr_q + 2'd1;
        end
        if (fifo_pop) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
        end
        case ({fifo_push, fifo_pop})
            2'b10:   cnt_d = cnt_q + 3'd1;
            2'b01:   cnt_d = cnt_q - 3'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            cnt_q    <= 3'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: clearing the pointers and count discards it.
    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_mem_q[wr_ptr_q] <= uart_rx_data;
        end
    end

    // ---------------- tx holding register ----------------
    logic       tx_valid_q, tx_valid_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       tx_free;

    assign tx_free = !tx_valid_q;

    always_comb begin
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        if (tx_valid_q) begin
            if (uart_tx_ready) begin
                tx_valid_d = 1'b0;
            end
        end else if (is_store && hit_tx) begin
            tx_valid_d = 1'b1;
            tx_data_d  = mem_wdataM[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
        end else begin
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
        end
    end

    assign uart_tx_valid = tx_valid_q;
    assign uart_tx_data  = tx_data_q;

    // ---------------- performance counters ----------------
    logic [31:0] cyc_cnt_q, cyc_cnt_d;
    logic [31:0] ins_cnt_q, ins_cnt_d;
    logic        cnt_clr;

    assign cnt_clr = is_store && hit_crst;

    always_comb begin
        cyc_cnt_d = cyc_cnt_q + 32'd1;
        ins_cnt_d = instr_stop ? ins_cnt_q : (ins_cnt_q + 32'd1);
        if (cnt_clr) begin
            cyc_cnt_d = 32'd0;
            ins_cnt_d = 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_cnt_q <= 32'd0;
            ins_cnt_q <= 32'd0;
        end else begin
            cyc_cnt_q <= cyc_cnt_d;
            ins_cnt_q <= ins_cnt_d;
        end
    end

    // ---------------- read data ----------------
    logic [31:0] rdata_d;
    logic [31:0] io_dout_q;

    always_comb begin
        rdata_d = 32'd0;
        if (io_sel) begin
            case (mem_adrM[27:0])
                ADR_STATUS[27:0]: rdata_d = {30'd0, !fifo_empty, tx_free};
                ADR_RX[27:0]:     rdata_d = fifo_empty ? 32'd0 : {24'd0, fifo_mem_q[rd_ptr_q]};
                ADR_CYC[27:0]:    rdata_d = cyc_cnt_q;
                ADR_INSTR[27:0]:  rdata_d = ins_cnt_q;
                default:          rdata_d = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            io_dout_q <= 32'd0;
        end else begin
            io_dout_q <= rdata_d;
        end
    end

    assign io_dout = io_dout_q;

endmodule

// File: tb/tb_mmio_ctrl.sv
// Randomized scoreboard bench for mmio_ctrl with a queue-based reference model
// plus directed scenarios for counters, FIFO fill, tx hold and reset abort.
module tb_mmio_ctrl;

    localparam logic [31:0] ADR_STATUS = 32'h8000_0000;
    localparam logic [31:0] ADR_RX     = 32'h8000_0004;
    localparam logic [31:0] ADR_TX     = 32'h8000_0008;
    localparam logic [31:0] ADR_CYC    = 32'h8000_0010;
    localparam logic [31:0] ADR_INSTR  = 32'h8000_0014;
    localparam logic [31:0] ADR_CRST   = 32'h8000_0018;

    logic        clk;
    logic        rst;
    logic [31:0] mem_adrM;
    logic [31:0] mem_wdataM;
    logic [3:0]  wea;
    logic        mem_re;
    logic        instr_stop;
    logic [31:0] io_dout;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_valid;
    logic        uart_tx_ready;
    logic [7:0]  uart_rx_data;
    logic        uart_rx_valid;
    logic        uart_rx_ready;

    mmio_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .mem_adrM     (mem_adrM),
        .mem_wdataM   (mem_wdataM),
        .wea          (wea),
        .mem_re       (mem_re),
        .instr_stop   (instr_stop),
        .io_dout      (io_dout),
        .uart_tx_data (uart_tx_data),
        .uart_tx_valid(uart_tx_valid),
        .uart_tx_ready(uart_tx_ready),
        .uart_rx_data (uart_rx_data),
        .uart_rx_valid(uart_rx_valid),
        .uart_rx_ready(uart_rx_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] dout;
        logic        tv;
        logic [7:0]  td;
        logic        rr;
    } exp_t;

    exp_t        expq[$];
    int          n_vec = 0;
    int          n_err = 0;

    // stimulus for the next cycle
    logic        s_rst;
    logic [31:0] s_adr;
    logic [31:0] s_wdata;
    logic [3:0]  s_wea;
    logic        s_re;
    logic        s_stop;
    logic        s_txr;
    logic [7:0]  rx_src[$];

    // reference model state
    logic [7:0]  mq[$];
    logic        m_txv;
    logic [7:0]  m_txd;
    logic [31:0] m_cyc;
    logic [31:0] m_ins;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
        end
    endfunction

    task automatic idle();
        s_rst = 1'b0; s_adr = 32'h0; s_wdata = 32'h0; s_wea = 4'h0;
        s_re = 1'b0; s_stop = 1'b0; s_txr = 1'b1;
    endtask

    // Apply one cycle of stimulus and push what the outputs must be after the edge.
    task automatic step();
        exp_t        e;
        int          sz;
        logic [31:0] rd;
        @(negedge clk);
        rst           = s_rst;
        mem_adrM      = s_adr;
        mem_wdataM    = s_wdata;
        wea           = s_wea;
        mem_re        = s_re;
        instr_stop    = s_stop;
        uart_tx_ready = s_txr;
        uart_rx_valid = (rx_src.size() > 0);
        uart_rx_data  = (rx_src.size() > 0) ? rx_src[0] : 8'h00;
        if (s_rst) begin
            mq.delete();
            m_txv = 1'b0; m_txd = 8'h00; m_cyc = 32'h0; m_ins = 32'h0;
            e.dout = 32'h0;
        end else begin
            sz = mq.size();
            rd = 32'h0;
            if (s_adr == ADR_STATUS)     rd = {30'd0, sz != 0, !m_txv};
            else if (s_adr == ADR_RX)    rd = (sz > 0) ? {24'd0, mq[0]} : 32'h0;
            else if (s_adr == ADR_CYC)   rd = m_cyc;
            else if (s_adr == ADR_INSTR) rd = m_ins;
            e.dout = rd;
            if (s_re && s_adr == ADR_RX && sz > 0) void'(mq.pop_front());
            if (rx_src.size() > 0 && sz < 4) begin
                mq.push_back(rx_src[0]);
                void'(rx_src.pop_front());
            end
            if (m_txv) begin
                if (s_txr) m_txv = 1'b0;
            end else if (s_wea != 4'h0 && s_adr == ADR_TX) begin
                m_txv = 1'b1;
                m_txd = s_wdata[7:0];
            end
            if (s_wea != 4'h0 && s_adr == ADR_CRST) begin
                m_cyc = 32'h0;
                m_ins = 32'h0;
            end else begin
                m_cyc = m_cyc + 32'd1;
                if (!s_stop) m_ins = m_ins + 32'd1;
            end
        end
        e.tv = m_txv;
        e.td = m_txd;
        e.rr = (mq.size() < 4);
        expq.push_back(e);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Monitor: every edge that has a pending expectation is checked here.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("io_dout", io_dout, e.dout);
                chk("tx_valid", {31'd0, uart_tx_valid}, {31'd0, e.tv});
                chk("tx_data", {24'd0, uart_tx_data}, {24'd0, e.td});
                chk("rx_ready", {31'd0, uart_rx_ready}, {31'd0, e.rr});
            end
        end
    end

    initial begin
        logic [7:0]  exp_pop [5];
        logic [31:0] a;
        int          sel;
        exp_pop[0] = 8'h41; exp_pop[1] = 8'h42; exp_pop[2] = 8'h43;
        exp_pop[3] = 8'h44; exp_pop[4] = 8'h45;

        rst = 1'b1; mem_adrM = 32'h0; mem_wdataM = 32'h0; wea = 4'h0;
        mem_re = 1'b0; instr_stop = 1'b0; uart_tx_ready = 1'b1;
        uart_rx_data = 8'h00; uart_rx_valid = 1'b0;

        // Reset, idle 10 cycles, read cycle counter and status
        idle(); s_rst = 1'b1;
        step(); step();
        settle();
        chk("reset_dout", io_dout, 32'h0);
        chk("reset_txv", {31'd0, uart_tx_valid}, 32'h0);
        chk("reset_rxr", {31'd0, uart_rx_ready}, 32'h1);
        idle();
        repeat (10) step();
        s_adr = ADR_CYC; step(); settle();
        chk("cyc_after_10", io_dout, 32'd10);
        s_adr = ADR_STATUS; step(); settle();
        chk("status_idle", io_dout, 32'h1);

        // Fill the rx FIFO with five bytes, no reads
        idle();
        for (int i = 0; i < 5; i++) rx_src.push_back(exp_pop[i]);
        repeat (4) step();
        settle();
        chk("rx_full_ready", {31'd0, uart_rx_ready}, 32'h0);
        step(); step(); settle();
        chk("rx_held_ready", {31'd0, uart_rx_ready}, 32'h0);
        chk("rx_held_valid", {31'd0, uart_rx_valid}, 32'h1);
        for (int i = 0; i < 5; i++) begin
            s_re = 1'b1; s_adr = ADR_RX;
            step(); settle();
            chk("rx_pop", io_dout, {24'd0, exp_pop[i]});
        end
        s_adr = ADR_RX; step(); settle();
        chk("rx_pop_empty", io_dout, 32'h0);

        // tx hold with ready low, second store dropped
        idle(); s_txr = 1'b0; s_adr = ADR_TX; s_wdata = 32'hFFFF_FF5A; s_wea = 4'h1;
        step(); settle();
        chk("tx_load_v", {31'd0, uart_tx_valid}, 32'h1);
        chk("tx_load_d", {24'd0, uart_tx_data}, 32'h5A);
        s_wdata = 32'h0000_0011; s_wea = 4'hF;
        step(); settle();
        chk("tx_drop_d", {24'd0, uart_tx_data}, 32'h5A);
        idle(); s_txr = 1'b0;
        step(); settle();
        chk("tx_hold_v", {31'd0, uart_tx_valid}, 32'h1);
        idle(); step(); settle();
        chk("tx_done_v", {31'd0, uart_tx_valid}, 32'h0);
        s_adr = ADR_STATUS; step(); settle();
        chk("tx_status", io_dout, 32'h1);

        // Counter reset, then instr_stop high 4 of 10 cycles
        idle(); s_adr = ADR_CRST; s_wea = 4'hF;
        step();
        idle();
        for (int i = 0; i < 10; i++) begin
            s_stop = (i % 3 == 1) || (i == 9);
            step();
        end
        s_stop = 1'b1; s_adr = ADR_CYC; step(); settle();
        chk("cnt_cyc10", io_dout, 32'd10);
        s_adr = ADR_INSTR; step(); settle();
        chk("cnt_ins6", io_dout, 32'd6);

        // Cycle counter wrap via preload, then clear coincident with increment
        force dut.cyc_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.cyc_cnt_q;
        m_cyc = 32'hFFFF_FFFE;
        idle(); s_adr = ADR_CYC;
        step(); settle();
        chk("wrap_fffe", io_dout, 32'hFFFF_FFFE);
        step(); settle();
        chk("wrap_ffff", io_dout, 32'hFFFF_FFFF);
        step(); settle();
        chk("wrap_zero", io_dout, 32'h0);
        s_adr = ADR_CRST; s_wea = 4'h2; step();
        s_wea = 4'h0; s_adr = ADR_CYC; step(); settle();
        chk("clr_wins", io_dout, 32'h0);

        // Reset aborts tx and discards two FIFO entries
        idle();
        rx_src.push_back(8'h61); rx_src.push_back(8'h62);
        step(); step();
        s_txr = 1'b0; s_adr = ADR_TX; s_wdata = 32'h77; s_wea = 4'h1;
        step(); settle();
        chk("pre_rst_txv", {31'd0, uart_tx_valid}, 32'h1);
        idle(); s_txr = 1'b0; s_rst = 1'b1;
        step(); settle();
        chk("rst_txv", {31'd0, uart_tx_valid}, 32'h0);
        idle(); s_txr = 1'b0; s_adr = ADR_STATUS;
        step(); settle();
        chk("rst_status", io_dout, 32'h1);
        s_re = 1'b1; s_adr = ADR_RX;
        step(); settle();
        chk("rst_pop", io_dout, 32'h0);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            idle();
            sel = $urandom_range(0, 10);
            a = $urandom();
            if (a[31:28] == 4'h8) a[31:28] = 4'h1;
            case (sel)
                0:       s_adr = ADR_STATUS;
                1, 2:    s_adr = ADR_RX;
                3, 4:    s_adr = ADR_TX;
                5:       s_adr = ADR_CYC;
                6:       s_adr = ADR_INSTR;
                7:       s_adr = ($urandom_range(0, 3) == 0) ? ADR_CRST : 32'h8000_000C;
                8:       s_adr = {4'h0, 28'h000_0004};
                9:       s_adr = {4'h8, a[27:0]};
                default: s_adr = a;
            endcase
            s_wdata = $urandom();
            s_wea   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            s_re    = ($urandom_range(0, 1) == 1);
            s_stop  = ($urandom_range(0, 2) == 0);
            s_txr   = ($urandom_range(0, 2) != 0);
            s_rst   = ($urandom_range(0, 199) == 0);
            if (rx_src.size() == 0 && $urandom_range(0, 2) == 0)
                rx_src.push_back(8'($urandom()));
            step();
        end
        idle(); rx_src.delete();
        step(); step();
        settle(); settle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
